avalon_timeout_bridge: RTL and testbench
========================================

Name: avalon_timeout_bridge

Overview:
- Single-transaction Avalon-MM bridge placed directly downstream of the virtual-JTAG Avalon master, between that master and the system interconnect.
- Registers each read/write command and forwards it to the fabric.
- Enforces a bounded wait so a hung slave cannot lock the JTAG debug path. On timeout it returns a fixed error word and records sticky status readable by host software.

Parameters:
- DATA_WIDTH, 32, data bus width on both sides.
- ADDR_WIDTH, 32, address width on both sides.
- TIMEOUT_CYCLES, 1024, maximum master-side cycles spent waiting per transaction; 0 disables the timeout.
- TIMEOUT_DATA, 32'hDEAD_BEEF, readdata returned upstream when a read times out.
- CNT_WIDTH, 16, width of the saturating timeout event counter.

Ports:
- avs_br_clk  in  1  single clock for both sides.
- avs_br_reset_n  in  1  asynchronous, active-low reset.
- avs_br_address  in  ADDR_WIDTH  upstream address.
- avs_br_read  in  1  upstream read request, held until waitrequest is low.
- avs_br_write  in  1  upstream write request, held until waitrequest is low.
- avs_br_writedata  in  DATA_WIDTH  upstream write data.
- avs_br_readdata  out  DATA_WIDTH  upstream read data, valid when avs_br_waitrequest is low.
- avs_br_waitrequest  out  1  upstream stall; low for exactly one cycle per completed transaction.
- avm_br_address  out  ADDR_WIDTH  downstream address (registered).
- avm_br_read  out  1  downstream read.
- avm_br_write  out  1  downstream write.
- avm_br_writedata  out  DATA_WIDTH  downstream write data (registered).
- avm_br_readdata  in  DATA_WIDTH  downstream read data.
- avm_br_waitrequest  in  1  downstream stall.
- err_clear  in  1  single-cycle pulse that clears timeout_flag, timeout_count and cmd_err.
- timeout_flag  out  1  sticky; set by any timeout.
- timeout_count  out  CNT_WIDTH  saturating count of timeouts.
- cmd_err  out  1  sticky; set when read and write are sampled high together.

Behaviour:
- Reset (asynchronous, avs_br_reset_n low): state = IDLE. avs_br_waitrequest=1. avm_br_read/write=0. avm_br_address, avm_br_writedata, avs_br_readdata = 0. Timer = 0. All status outputs = 0.
- Reset asserted mid-transaction: the downstream command is dropped immediately and no upstream completion is issued.
- The FSM is fully registered and has states IDLE, ISSUE, DONE.
- IDLE:
  - avs_br_waitrequest=1.
  - If avs_br_read or avs_br_write is high: latch address, writedata and op type, clear the timer, and go to ISSUE.
  - Both read and write high: perform the read only and set cmd_err.
- ISSUE:
  - avm_br_read or avm_br_write is driven high from the latched op; address and data stay stable.
  - The timer increments each cycle.
  - If avm_br_waitrequest is low: capture avm_br_readdata into avs_br_readdata (reads only; writes leave readdata unchanged) and go to DONE.
  - Else, if TIMEOUT_CYCLES != 0 and the timer equals TIMEOUT_CYCLES-1: on a read, load TIMEOUT_DATA into avs_br_readdata. Set timeout_flag, increment timeout_count (saturating at all-ones), and go to DONE.
  - Completion has priority over timeout when both occur in the same cycle.
- DONE:
  - avs_br_waitrequest=0 for exactly one cycle; avm_br_read and avm_br_write are 0.
  - Go to IDLE unconditionally. The upstream master drops its request on this same edge, so no re-issue occurs.
- Latency with a zero-wait slave: request sampled in cycle 0, avm strobe in cycle 1, avs_br_waitrequest low in cycle 2.
- Downstream strobe duration is (slave wait cycles + 1), capped at TIMEOUT_CYCLES.
- err_clear in the same cycle as a new timeout or cmd_err event: the set wins. The counter then reads 1, not the prior value + 1.
- Timeouts are write-silent: no error data is returned upstream, only status is updated.
- A late slave response after a timeout is ignored, because the strobe is already deasserted.

Decomposition:
- Shared package avalon_bridge_pkg holds:
  - the state enum (IDLE, ISSUE, DONE);
  - default TIMEOUT_CYCLES and TIMEOUT_DATA constants;
  - a timer-width function returning clog2(TIMEOUT_CYCLES+1).
- One natural sub-module: avalon_br_timer, a clearable, enabled up-counter with a terminal-count output.
- Everything else stays in the top-level module.

Test Plan:
- Zero-wait read at address 0x10, slave returns 0x1234_5678 -> avm_br_read is high for 1 cycle; avs_br_waitrequest is low in cycle 2 with readdata 0x1234_5678; no status change.
- Write 0xA5A5_A5A5 to 0x20, slave waitrequest held for 5 cycles -> avm_br_write is high for 6 cycles with stable address/data; one upstream completion; timeout_flag stays 0.
- TIMEOUT_CYCLES=8, read to a slave that never responds -> avm_br_read is high for exactly 8 cycles; readdata 0xDEAD_BEEF; timeout_flag=1; timeout_count=1.
- CNT_WIDTH=2, five consecutive timeouts -> timeout_count saturates at 3. Then err_clear -> flag and count return to 0. err_clear coincident with a timeout -> flag=1, count=1.
- avs_br_read and avs_br_write high together -> only a read is issued downstream; cmd_err=1.
- avs_br_reset_n pulsed low during ISSUE -> avm strobes drop asynchronously; no waitrequest-low pulse appears; the next read completes normally.

Source files
------------

// File: rtl/avalon_bridge_pkg.sv
// Purpose: shared types and constants for the Avalon timeout bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package avalon_bridge_pkg;

  // Bridge FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } br_state_t;

  localparam int          DEF_TIMEOUT_CYCLES = 1024;
  localparam logic [31:0] DEF_TIMEOUT_DATA   = 32'hDEAD_BEEF;

  // Bits needed to hold 0..cycles. Never narrower than one bit, so that a
  // disabled timeout (cycles == 0) still produces a legal vector width.
  function automatic int timer_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/avalon_br_timer.sv
// Purpose: clearable, enabled up-counter flagging when it sits at a terminal value.
// Latency: count updates one cycle after enable/clear; at_terminal is combinational on count.
// Backpressure: none; clear has priority over enable.
module avalon_br_timer #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             at_terminal
);

  logic [WIDTH-1:0] count;

  // Count up while enabled; clear returns to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_terminal = (count == terminal);

endmodule

// File: rtl/avalon_timeout_bridge.sv
// Purpose: single-outstanding Avalon-MM bridge with a bounded downstream wait and sticky error status.
// Latency: zero-wait slave completes upstream two cycles after the request is sampled.
// Backpressure: upstream held via waitrequest until downstream answers or the timer expires.
module avalon_timeout_bridge
  import avalon_bridge_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(DEF_TIMEOUT_DATA),
  parameter int                    CNT_WIDTH      = 16
) (
  input  logic                  avs_br_clk,
  input  logic                  avs_br_reset_n,
  input  logic [ADDR_WIDTH-1:0] avs_br_address,
  input  logic                  avs_br_read,
  input  logic                  avs_br_write,
  input  logic [DATA_WIDTH-1:0] avs_br_writedata,
  output logic [DATA_WIDTH-1:0] avs_br_readdata,
  output logic                  avs_br_waitrequest,
  output logic [ADDR_WIDTH-1:0] avm_br_address,
  output logic                  avm_br_read,
  output logic                  avm_br_write,
  output logic [DATA_WIDTH-1:0] avm_br_writedata,
  input  logic [DATA_WIDTH-1:0] avm_br_readdata,
  input  logic                  avm_br_waitrequest,
  input  logic                  err_clear,
  output logic                  timeout_flag,
  output logic [CNT_WIDTH-1:0]  timeout_count,
  output logic                  cmd_err
);

  localparam int            TW       = timer_width(TIMEOUT_CYCLES);
  localparam int            TERM_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [TW-1:0] TERM     = TW'(TERM_INT);
  localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);

  br_state_t            state;
  logic                 op_read;
  logic                 at_term;
  logic                 timeout_hit;
  logic                 cmd_conflict;
  logic [CNT_WIDTH-1:0] cnt_base;

  // Timer sits at zero while idle, so every transaction starts its wait from 0.
  avalon_br_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk         (avs_br_clk),
    .rst_n       (avs_br_reset_n),
    .clear       (state == IDLE),
    .enable      (state == ISSUE),
    .terminal    (TERM),
    .at_terminal (at_term)
  );

  // A response arriving on the terminal cycle wins, hence the waitrequest qualifier.
  assign timeout_hit  = TO_EN && (state == ISSUE) && avm_br_waitrequest && at_term;
  assign cmd_conflict = (state == IDLE) && avs_br_read && avs_br_write;
  // A coincident clear restarts the count from zero before the new event is added.
  assign cnt_base     = err_clear ? '0 : timeout_count;

  // Bridge FSM with registered upstream and downstream handshakes.
  always_ff @(posedge avs_br_clk or negedge avs_br_reset_n) begin
    if (!avs_br_reset_n) begin
      state              <= IDLE;
      op_read            <= 1'b0;
      avs_br_waitrequest <= 1'b1;
      avs_br_readdata    <= '0;
      avm_br_address     <= '0;
      avm_br_writedata   <= '0;
      avm_br_read        <= 1'b0;
      avm_br_write       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          avs_br_waitrequest <= 1'b1;
          if (avs_br_read || avs_br_write) begin
            avm_br_address   <= avs_br_address;
            avm_br_writedata <= avs_br_writedata;
            op_read          <= avs_br_read;
            // Read wins when both strobes are raised together.
            avm_br_read      <= avs_br_read;
            avm_br_write     <= avs_br_write && !avs_br_read;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (!avm_br_waitrequest) begin
            if (op_read) begin
              avs_br_readdata <= avm_br_readdata;
            end
            avm_br_read        <= 1'b0;
            avm_br_write       <= 1'b0;
            avs_br_waitrequest <= 1'b0;
            state              <= DONE;
          end else if (timeout_hit) begin
            // Writes complete silently; only reads see the error word.
            if (op_read) begin
              avs_br_readdata <= TIMEOUT_DATA;
            end
            avm_br_read        <= 1'b0;
            avm_br_write       <= 1'b0;
            avs_br_waitrequest <= 1'b0;
            state              <= DONE;
          end
        end
        DONE: begin
          // Upstream drops its request on this edge, so no re-issue follows.
          avs_br_waitrequest <= 1'b1;
          state              <= IDLE;
        end
        default: begin
          avs_br_waitrequest <= 1'b1;
          avm_br_read        <= 1'b0;
          avm_br_write       <= 1'b0;
          state              <= IDLE;
        end
      endcase
    end
  end

  // Sticky status: a new event takes priority over a same-cycle clear.
  always_ff @(posedge avs_br_clk or negedge avs_br_reset_n) begin
    if (!avs_br_reset_n) begin
      timeout_flag  <= 1'b0;
      timeout_count <= '0;
      cmd_err       <= 1'b0;
    end else begin
      if (timeout_hit) begin
        timeout_flag  <= 1'b1;
        timeout_count <= (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);
      end else if (err_clear) begin
        timeout_flag  <= 1'b0;
        timeout_count <= '0;
      end
      if (cmd_conflict) begin
        cmd_err <= 1'b1;
      end else if (err_clear) begin
        cmd_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avalon_timeout_bridge.sv
// Purpose: self-checking bench for avalon_timeout_bridge (TIMEOUT_CYCLES=8, CNT_WIDTH=2).
// Latency: expects completion at strobe cycles + 1 after the request is driven.
// Backpressure: slave model holds waitrequest for a programmable number of strobe cycles.
module tb_avalon_timeout_bridge;

  localparam int NEVER = 1000;

  typedef struct {
    logic [31:0] rdata;
    int          strobes;
    bit          down_read;
    bit          flag;
    logic [1:0]  cnt;
    bit          cmd;
  } exp_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          swait;
    logic [31:0] srdata;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        err_clear = 1'b0;
  logic        timeout_flag;
  logic [1:0]  timeout_count;
  logic        cmd_err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          swait = 0;
  int          scnt = 0;
  logic [31:0] srdata = '0;
  exp_t        sb[$];
  vec_t        vecs[9];

  always #5 clk = ~clk;

  avalon_timeout_bridge #(
    .TIMEOUT_CYCLES (8),
    .CNT_WIDTH      (2)
  ) dut (
    .avs_br_clk         (clk),
    .avs_br_reset_n     (rst_n),
    .avs_br_address     (address),
    .avs_br_read        (read),
    .avs_br_write       (write),
    .avs_br_writedata   (writedata),
    .avs_br_readdata    (readdata),
    .avs_br_waitrequest (waitrequest),
    .avm_br_address     (avm_address),
    .avm_br_read        (avm_read),
    .avm_br_write       (avm_write),
    .avm_br_writedata   (avm_writedata),
    .avm_br_readdata    (avm_readdata),
    .avm_br_waitrequest (avm_waitrequest),
    .err_clear          (err_clear),
    .timeout_flag       (timeout_flag),
    .timeout_count      (timeout_count),
    .cmd_err            (cmd_err)
  );

  // Slave model: answers on strobe cycle index swait (0-based).
  assign avm_waitrequest = !((avm_read || avm_write) && (scnt == swait));
  assign avm_readdata    = srdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            scnt <= 0;
    else if ((avm_read || avm_write) && avm_waitrequest) scnt <= scnt + 1;
    else                                   scnt <= 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input bit flag, input logic [1:0] cnt, input bit cmd);
    chk({tag, ".timeout_flag"}, 64'(timeout_flag), 64'(flag));
    chk({tag, ".timeout_count"}, 64'(timeout_count), 64'(cnt));
    chk({tag, ".cmd_err"}, 64'(cmd_err), 64'(cmd));
  endtask

  // Drive one upstream transaction; optionally pulse err_clear after strobe cycle clr_at.
  task automatic do_txn(input string tag, input vec_t v, input int clr_at);
    exp_t e;
    int   strobes;
    int   lat;
    bit   done;
    bit   saw_rd;
    bit   saw_wr;
    bit   stable;
    sb.push_back(v.exp);
    @(negedge clk);
    address = v.addr; writedata = v.wdata; read = v.rd; write = v.wr;
    swait = v.swait; srdata = v.srdata;
    strobes = 0; done = 0; saw_rd = 0; saw_wr = 0; stable = 1; lat = 0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      err_clear = 1'b0;
      if (avm_read || avm_write) begin
        strobes++;
        saw_rd |= avm_read;
        saw_wr |= avm_write;
        if (avm_address !== v.addr) stable = 0;
        if (avm_write && avm_writedata !== v.wdata) stable = 0;
      end
      if (!waitrequest) begin
        done = 1;
        lat = k;
        e = sb.pop_front();
        chk({tag, ".readdata"}, 64'(readdata), 64'(e.rdata));
        chk({tag, ".strobes"}, 64'(strobes), 64'(e.strobes));
        chk({tag, ".latency"}, 64'(lat), 64'(e.strobes + 1));
        chk({tag, ".down_op"}, {62'd0, saw_rd, saw_wr}, {62'd0, e.down_read, !e.down_read});
        chk({tag, ".stable"}, 64'(stable), 64'd1);
        chk_status(tag, e.flag, e.cnt, e.cmd);
        read = 1'b0; write = 1'b0;
      end else if (k == clr_at) begin
        err_clear = 1'b1;
      end
    end
    err_clear = 1'b0;
    if (!done) begin
      chk({tag, ".completion_timeout"}, 64'd0, 64'd1);
      read = 1'b0; write = 1'b0;
      void'(sb.pop_front());
    end
    // The completion pulse must last exactly one cycle.
    @(negedge clk);
    chk({tag, ".waitreq_rehigh"}, 64'(waitrequest), 64'd1);
  endtask

  initial begin
    //               rd wr addr       wdata         swait  srdata        {rdata strobes dread flag cnt cmd}
    vecs[0] = '{1, 0, 32'h10, 32'h0,         0,     32'h1234_5678, '{32'h1234_5678, 1, 1, 0, 2'd0, 0}};
    vecs[1] = '{0, 1, 32'h20, 32'hA5A5_A5A5, 5,     32'h0,         '{32'h1234_5678, 6, 0, 0, 2'd0, 0}};
    vecs[2] = '{1, 0, 32'h30, 32'h0,         7,     32'h0BAD_F00D, '{32'h0BAD_F00D, 8, 1, 0, 2'd0, 0}};
    vecs[3] = '{1, 0, 32'h40, 32'h0,         NEVER, 32'h1111_1111, '{32'hDEAD_BEEF, 8, 1, 1, 2'd1, 0}};
    vecs[4] = '{0, 1, 32'h44, 32'h0000_0001, NEVER, 32'h0,         '{32'hDEAD_BEEF, 8, 0, 1, 2'd2, 0}};
    vecs[5] = '{1, 1, 32'h50, 32'h7777_7777, 2,     32'h55AA_55AA, '{32'h55AA_55AA, 3, 1, 1, 2'd2, 1}};
    vecs[6] = '{1, 0, 32'h60, 32'h0,         NEVER, 32'h0,         '{32'hDEAD_BEEF, 8, 1, 1, 2'd3, 1}};
    vecs[7] = '{1, 0, 32'h64, 32'h0,         NEVER, 32'h0,         '{32'hDEAD_BEEF, 8, 1, 1, 2'd3, 1}};
    vecs[8] = '{0, 1, 32'h68, 32'h0000_0002, NEVER, 32'h0,         '{32'hDEAD_BEEF, 8, 0, 1, 2'd3, 1}};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.waitrequest", 64'(waitrequest), 64'd1);
    chk("rst.avm_strobes", {62'd0, avm_read, avm_write}, 64'd0);
    chk("rst.avm_address", 64'(avm_address), 64'd0);
    chk("rst.avm_writedata", 64'(avm_writedata), 64'd0);
    chk("rst.readdata", 64'(readdata), 64'd0);
    chk_status("rst", 0, 2'd0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.waitrequest", 64'(waitrequest), 64'd1);

    for (int i = 0; i < 9; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i], 0);
    end

    // Standalone clear
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
    chk_status("clear", 0, 2'd0, 0);

    // One timeout, then a timeout coincident with err_clear: count restarts at 1
    do_txn("to_a", '{1, 0, 32'h80, 32'h0, NEVER, 32'h0, '{32'hDEAD_BEEF, 8, 1, 1, 2'd1, 0}}, 0);
    do_txn("to_clr", '{1, 0, 32'h84, 32'h0, NEVER, 32'h0, '{32'hDEAD_BEEF, 8, 1, 1, 2'd1, 0}}, 8);

    // Reset in the middle of ISSUE
    @(negedge clk);
    address = 32'h70; read = 1'b1; swait = NEVER;
    repeat (3) @(negedge clk);
    chk("mid.strobe_before", 64'(avm_read), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.strobe_dropped", {62'd0, avm_read, avm_write}, 64'd0);
    read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid.no_completion", 64'(waitrequest), 64'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid.no_completion_after", 64'(waitrequest), 64'd1);
    chk_status("mid", 0, 2'd0, 0);
    chk("mid.readdata", 64'(readdata), 64'd0);
    do_txn("post_rst", '{1, 0, 32'h74, 32'h0, 0, 32'hCAFE_0001, '{32'hCAFE_0001, 1, 1, 0, 2'd0, 0}}, 0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
